// File: rtl/game_ctl_pkg.sv
// game_ctl_pkg: shared state codes and playfield geometry defaults for the game sequencer.
package game_ctl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_MISS = 3'd2,
        ST_OVER = 3'd3
    } state_t;
    localparam int SCREEN_W_D   = 1024;
    localparam int SCREEN_H_D   = 768;
    localparam int BALL_SIZE_D  = 16;
    localparam int PADDLE_W_D   = 128;
    localparam int PADDLE_Y_D   = 720;
    localparam int BALL_SPEED_D = 4;
    localparam int LIVES_D      = 3;
endpackage

// File: rtl/game_ctl_sync_edge.sv
// sync_edge: optional 2-FF synchroniser followed by a rising-edge pulse generator.
module sync_edge #(
    parameter bit SYNC = 1'b1
)(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);
    localparam int N = SYNC ? 3 : 2;
    logic [N-1:0] sh_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sh_q <= '0;
        else       sh_q <= {sh_q[N-2:0], d_i};
    end
    assign rise_o = sh_q[N-2] & ~sh_q[N-1];
endmodule

// File: rtl/game_ctl.sv
// game_ctl: per-frame ball motion, wall/paddle bounces, misses and lives for the Arkanoid pipeline.
// Define GAME_CTL_SPEEDUP_EN to speed the ball up by 1 px every 8th paddle hit (max 8).
module game_ctl
    import game_ctl_pkg::*;
#(
    parameter int SCREEN_W   = SCREEN_W_D,
    parameter int SCREEN_H   = SCREEN_H_D,
    parameter int BALL_SIZE  = BALL_SIZE_D,
    parameter int PADDLE_W   = PADDLE_W_D,
    parameter int PADDLE_Y   = PADDLE_Y_D,
    parameter int BALL_SPEED = BALL_SPEED_D,
    parameter int LIVES      = LIVES_D
)(
    input  logic        pclk,
    input  logic        reset,
    input  logic        vblnk_in,
    input  logic        mouse_left,
    input  logic [11:0] paddle_x,
    output logic [11:0] ball_x,
    output logic [11:0] ball_y,
    output logic [1:0]  lives,
    output logic [2:0]  state,
    output logic        game_over
);
    localparam logic signed [12:0] BS   = 13'(BALL_SIZE);
    localparam logic signed [12:0] PY   = 13'(PADDLE_Y);
    localparam logic signed [12:0] PW   = 13'(PADDLE_W);
    localparam logic signed [12:0] SH   = 13'(SCREEN_H);
    localparam logic signed [12:0] XMAX = 13'(SCREEN_W - BALL_SIZE);
    localparam logic [11:0] REST_Y = 12'(PADDLE_Y - BALL_SIZE);
    localparam logic [11:0] PC_MAX = 12'(SCREEN_W - PADDLE_W);

    state_t            state_q;
    logic [1:0]        lives_q;
    logic              go_q, dxn_q, dyn_q, pend_q;
    logic [11:0]       bx_q, by_q, bx_d, by_d, pc, cx;
    logic              v_tick, m_rise, click, lft, rgt, top, hit_d, miss_d, dxn_d, dyn_d;
    logic [3:0]        spd;
    logic signed [12:0] step, nx, ny, x1, y1, pcs;

`ifdef GAME_CTL_SPEEDUP_EN
    logic [3:0] spd_q;
    logic [2:0] hits_q;
    assign spd = spd_q;
`else
    assign spd = 4'(BALL_SPEED);
`endif

    sync_edge #(.SYNC(1'b0)) u_vblnk (.clk_i(pclk), .rst_i(reset), .d_i(vblnk_in),   .rise_o(v_tick));
    sync_edge #(.SYNC(1'b1)) u_mouse (.clk_i(pclk), .rst_i(reset), .d_i(mouse_left), .rise_o(m_rise));

    // One RUN step: walls first (left, right, top), then the paddle, then the miss line.
    always_comb begin
        pc     = (paddle_x > PC_MAX) ? PC_MAX : paddle_x;
        cx     = pc + 12'(PADDLE_W / 2 - BALL_SIZE / 2);
        pcs    = signed'({1'b0, pc});
        step   = signed'({9'd0, spd});
        nx     = signed'({1'b0, bx_q}) + (dxn_q ? -step : step);
        ny     = signed'({1'b0, by_q}) + (dyn_q ? -step : step);
        lft    = nx <= 13'sd0;
        rgt    = nx >= XMAX;
        top    = ny <= 13'sd0;
        x1     = lft ? 13'sd0 : rgt ? XMAX : nx;
        y1     = top ? 13'sd0 : ny;
        dxn_d  = lft ? 1'b0 : rgt ? 1'b1 : dxn_q;
        hit_d  = !dyn_q && signed'({1'b0, by_q}) + BS <= PY && ny + BS >= PY && x1 + BS > pcs && x1 < pcs + PW;
        miss_d = !hit_d && ny >= SH;
        dyn_d  = hit_d ? 1'b1 : top ? 1'b0 : dyn_q;
        bx_d   = x1[11:0];
        by_d   = hit_d ? REST_Y : y1[11:0];
        click  = pend_q | m_rise;
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lives_q <= 2'(LIVES);
            go_q    <= 1'b0;
            bx_q    <= 12'(SCREEN_W / 2 - BALL_SIZE / 2);
            by_q    <= REST_Y;
            dxn_q   <= 1'b0;
            dyn_q   <= 1'b1;
            pend_q  <= 1'b0;
`ifdef GAME_CTL_SPEEDUP_EN
            spd_q   <= 4'(BALL_SPEED);
            hits_q  <= 3'd0;
`endif
        end else begin
            pend_q <= v_tick ? 1'b0 : click;
            if (v_tick) begin
                case (state_q)
                    ST_IDLE: begin
                        bx_q <= click ? cx + {8'd0, spd} : cx;
                        by_q <= click ? REST_Y - {8'd0, spd} : REST_Y;
                        if (click) begin
                            state_q <= ST_RUN;
                            dxn_q   <= 1'b0;
                            dyn_q   <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (miss_d) state_q <= ST_MISS;
                        else begin
                            bx_q  <= bx_d;
                            by_q  <= by_d;
                            dxn_q <= dxn_d;
                            dyn_q <= dyn_d;
                        end
`ifdef GAME_CTL_SPEEDUP_EN
                        if (hit_d) begin
                            hits_q <= hits_q + 3'd1;
                            if (hits_q == 3'd7 && spd_q < 4'd8) spd_q <= spd_q + 4'd1;
                        end
`endif
                    end
                    ST_MISS: begin
                        dxn_q <= 1'b0;
                        dyn_q <= 1'b1;
`ifdef GAME_CTL_SPEEDUP_EN
                        spd_q  <= 4'(BALL_SPEED);
                        hits_q <= 3'd0;
`endif
                        if (lives_q == 2'd1) begin
                            lives_q <= 2'd0;
                            go_q    <= 1'b1;
                            state_q <= ST_OVER;
                        end else begin
                            lives_q <= lives_q - 2'd1;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_OVER: begin
                        if (click) begin
                            lives_q <= 2'(LIVES);
                            go_q    <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ball_x    = bx_q;
    assign ball_y    = by_q;
    assign lives     = lives_q;
    assign state     = state_q;
    assign game_over = go_q;
endmodule
